// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light phase timer and its seven-segment display path.
// bcd_digit_t is the digit type handed to the decoders.
package traffic_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Non-BCD codes are forced to 9 so the decoders never see A-F.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/phase_countdown_timer_bcd_digit_down.sv
// Single BCD digit down-counter with borrow chaining and clamp-on-load.
// q_next is exported so the parent can look one edge ahead.
module bcd_digit_down
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       borrow_in,
    output logic [3:0] q,
    output logic [3:0] q_next,
    output logic       borrow_out
);

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = bcd_clamp(load_val);
        end else if (borrow_in) begin
            q_next = (q == 4'd0) ? BCD_MAX : (q - 4'd1);
        end
    end

    assign borrow_out = borrow_in && (q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/phase_countdown_timer.sv
// Two-digit BCD countdown for the current traffic-light phase, with load/start/pause
// control and a one-cycle expired pulse. Optional macro: COUNTDOWN_LEADING_BLANK_EN.
module phase_countdown_timer
    import traffic_pkg::*;
#(
    parameter int PRESCALE = 50000000,
    parameter int PS_W     = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       tens_blank
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    timer_state_t    state, state_next;
    logic [PS_W-1:0] ps, ps_next;
    logic            tick;
    logic            expire_next;
    logic            ones_borrow;
    logic            tens_borrow_unused;
    logic [3:0]      ones_next, tens_next;

    // A tick only happens on a plain RUN cycle; load and pause both take precedence.
    always_comb begin
        tick = (state == ST_RUN) && !load && !pause && (ps == PS_LAST);
    end

    bcd_digit_down u_ones (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_ones),
        .borrow_in  (tick),
        .q          (ones),
        .q_next     (ones_next),
        .borrow_out (ones_borrow)
    );

    bcd_digit_down u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_tens),
        .borrow_in  (ones_borrow),
        .q          (tens),
        .q_next     (tens_next),
        .borrow_out (tens_borrow_unused)
    );

    always_comb begin
        state_next  = state;
        ps_next     = ps;
        expire_next = 1'b0;
        if (load) begin
            state_next = ST_IDLE;
            ps_next    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ps_next = '0;
                        if (tens == 4'd0 && ones == 4'd0) begin
                            state_next  = ST_EXPIRED;
                            expire_next = 1'b1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (tick) begin
                        ps_next = '0;
                        // Expire on the same edge that writes 00.
                        if (tens_next == 4'd0 && ones_next == 4'd0) begin
                            state_next  = ST_EXPIRED;
                            expire_next = 1'b1;
                        end
                    end else begin
                        ps_next = ps + PS_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    state_next = ST_EXPIRED;
                end
                default: begin
                    state_next = ST_IDLE;
                    ps_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ps      <= '0;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            ps      <= ps_next;
            running <= (state_next == ST_RUN);
            expired <= expire_next;
        end
    end

`ifdef COUNTDOWN_LEADING_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_blank <= 1'b0;
        end else begin
            tens_blank <= (tens_next == 4'd0);
        end
    end
`else
    assign tens_blank = 1'b0;
`endif

endmodule
